// File: rtl/cfi_check_sched_pkg.sv
// cfi_check_sched_pkg: log format, fault causes and scheduler states for the CFI check scheduler.
package cfi_check_sched_pkg;

    typedef struct packed {
        logic [31:0] src_pc;
        logic [31:0] dst_pc;
        logic [1:0]  kind;
    } cfi_log_t;

    typedef enum logic [1:0] {
        CAUSE_NONE     = 2'd0,
        CAUSE_CHECK    = 2'd1,
        CAUSE_TIMEOUT  = 2'd2,
        CAUSE_SPURIOUS = 2'd3
    } cfi_fault_cause_e;

    typedef enum logic [1:0] {
        RUN,
        FLUSH_WAIT,
        FLUSH_DISC,
        FAULT
    } cfi_sched_state_e;

endpackage

// File: rtl/cfi_check_sched.sv
// cfi_check_sched: pops CFI logs from the queue, issues them in order to the checker,
// tracks outstanding checks and sequences flush / fault recovery.
module cfi_check_sched
    import cfi_check_sched_pkg::*;
#(
    parameter int unsigned MAX_OUTSTANDING = 4,
    parameter int unsigned TIMEOUT         = 1024,
    parameter int unsigned CNT_W           = 32
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         enable_i,
    input  logic                         flush_i,
    input  logic                         fault_clear_i,
    input  logic                         queue_empty_i,
    input  logic [$bits(cfi_log_t)-1:0]  queue_data_i,
    output logic                         queue_pop_o,
    output logic                         chk_req_o,
    output logic [$bits(cfi_log_t)-1:0]  chk_data_o,
    input  logic                         chk_gnt_i,
    input  logic                         chk_rsp_valid_i,
    input  logic                         chk_rsp_fault_i,
    output logic                         cfi_fault_o,
    output logic [1:0]                   fault_cause_o,
    output logic                         flush_done_o,
    output logic                         idle_o,
    output logic [CNT_W-1:0]             checked_cnt_o
);
    localparam int unsigned OW = $clog2(MAX_OUTSTANDING + 1);
    localparam int unsigned TW = $clog2(TIMEOUT);

    cfi_sched_state_e state_q, state_d;
    cfi_fault_cause_e cause_q, cause_d;
    logic             req_v_q, req_v_d;
    cfi_log_t         req_d_q, req_d_d;
    logic [OW-1:0]    outst_q, outst_d;
    logic [TW-1:0]    tmo_q, tmo_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             hs, spurious, check_flt, timeout, fault, load, flush_fin;

    always_comb begin
        chk_req_o     = req_v_q && outst_q < OW'(MAX_OUTSTANDING) && state_q != FAULT;
        hs            = chk_req_o && chk_gnt_i;
        queue_pop_o   = state_q == RUN ? enable_i && !queue_empty_i && (!req_v_q || hs)
                                       : state_q == FLUSH_DISC && !queue_empty_i;
        spurious      = chk_rsp_valid_i && outst_q == '0;
        check_flt     = chk_rsp_valid_i && chk_rsp_fault_i;
        timeout       = outst_q != '0 && !chk_rsp_valid_i && tmo_q == TW'(TIMEOUT - 1);
        // once in FAULT the first cause is kept and later faults are ignored
        fault         = state_q != FAULT && (spurious || check_flt || timeout);
        flush_fin     = state_q == FLUSH_DISC && queue_empty_i && !fault;
        chk_data_o    = req_d_q;
        cfi_fault_o   = cause_q != CAUSE_NONE;
        fault_cause_o = cause_q;
        flush_done_o  = flush_fin;
        idle_o        = state_q == RUN && !req_v_q && outst_q == '0 && queue_empty_i;
        checked_cnt_o = cnt_q;
    end

    always_comb begin
        outst_d = outst_q + OW'(hs) - OW'(chk_rsp_valid_i && !spurious);
        case (state_q)
            RUN:        state_d = fault ? FAULT : flush_i ? FLUSH_WAIT : RUN;
            FLUSH_WAIT: state_d = fault ? FAULT : !req_v_q && outst_d == '0 ? FLUSH_DISC : FLUSH_WAIT;
            FLUSH_DISC: state_d = fault ? FAULT : queue_empty_i ? RUN : FLUSH_DISC;
            default:    state_d = fault_clear_i ? FLUSH_WAIT : FAULT;
        endcase
        load    = state_q == RUN && queue_pop_o;
        req_v_d = fault ? 1'b0 : load ? 1'b1 : hs ? 1'b0 : req_v_q;
        req_d_d = load ? cfi_log_t'(queue_data_i) : req_d_q;
        tmo_d   = state_q == FAULT ? tmo_q : outst_q == '0 || chk_rsp_valid_i ? '0 : tmo_q + TW'(1);
        cnt_d   = chk_rsp_valid_i && !chk_rsp_fault_i && !spurious && cnt_q != '1 ? cnt_q + CNT_W'(1) : cnt_q;
        cause_d = fault && cause_q == CAUSE_NONE
                ? (spurious ? CAUSE_SPURIOUS : check_flt ? CAUSE_CHECK : CAUSE_TIMEOUT)
                : flush_fin ? CAUSE_NONE : cause_q;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= RUN;
            cause_q <= CAUSE_NONE;
            req_v_q <= 1'b0;
            req_d_q <= '0;
            outst_q <= '0;
            tmo_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cause_q <= cause_d;
            req_v_q <= req_v_d;
            req_d_q <= req_d_d;
            outst_q <= outst_d;
            tmo_q   <= tmo_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_cfi_check_sched.sv
// tb_cfi_check_sched: scoreboarded bench for the CFI check scheduler (MAX_OUTSTANDING=4, TIMEOUT=16).
module tb_cfi_check_sched;
    import cfi_check_sched_pkg::*;
    localparam int LW = $bits(cfi_log_t);

    logic clk_i = 1'b0, rst_i = 1'b1, enable_i = 1'b0, flush_i = 1'b0, fault_clear_i = 1'b0;
    logic chk_gnt_i = 1'b0, chk_rsp_valid_i = 1'b0, chk_rsp_fault_i = 1'b0;
    logic queue_empty_i, queue_pop_o, chk_req_o, cfi_fault_o, flush_done_o, idle_o;
    logic [LW-1:0] queue_data_i, chk_data_o;
    logic [1:0]    fault_cause_o;
    logic [31:0]   checked_cnt_o;

    logic [LW-1:0] mem [64];
    int hd = 0;
    int tl = 0;
    int checks = 0;
    int errors = 0;
    int hs_cnt = 0;
    logic [LW-1:0] exp_q [$];
    logic [LW-1:0] exp_d;

    cfi_check_sched #(.MAX_OUTSTANDING(4), .TIMEOUT(16), .CNT_W(32)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .enable_i(enable_i), .flush_i(flush_i),
        .fault_clear_i(fault_clear_i), .queue_empty_i(queue_empty_i), .queue_data_i(queue_data_i),
        .queue_pop_o(queue_pop_o), .chk_req_o(chk_req_o), .chk_data_o(chk_data_o),
        .chk_gnt_i(chk_gnt_i), .chk_rsp_valid_i(chk_rsp_valid_i), .chk_rsp_fault_i(chk_rsp_fault_i),
        .cfi_fault_o(cfi_fault_o), .fault_cause_o(fault_cause_o), .flush_done_o(flush_done_o),
        .idle_o(idle_o), .checked_cnt_o(checked_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    assign queue_empty_i = (hd == tl);
    assign queue_data_i  = mem[hd & 63];

    // FIFO model consumes on pop; scoreboard compares every handshake against the expected order
    always @(posedge clk_i) begin
        if (queue_pop_o) hd <= hd + 1;
        if (chk_req_o && chk_gnt_i) begin
            hs_cnt++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL issue_unexpected: chk_data_o=%h issued, none expected", chk_data_o);
            end else begin
                exp_d = exp_q.pop_front();
                if (chk_data_o !== exp_d) begin
                    errors++;
                    $display("FAIL issue_data: chk_data_o=%h expected %h", chk_data_o, exp_d);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not finish by %0t", $time);
        $fatal(1);
    end

    function automatic logic [LW-1:0] mk(input int i);
        cfi_log_t l;
        l.src_pc = 32'h1000_0000 + 32'(i);
        l.dst_pc = 32'h2000_0000 + 32'(i * 3);
        l.kind   = 2'(i);
        return l;
    endfunction

    task automatic push(input logic [LW-1:0] d, input bit expect_issue);
        mem[tl & 63] = d;
        tl++;
        if (expect_issue) exp_q.push_back(d);
    endtask

    task automatic wait_done(output bit seen);
        seen = 1'b0;
        for (int i = 0; i < 30 && !seen; i++) begin
            @(negedge clk_i);
            seen = flush_done_o;
        end
    endtask

    task automatic test_reset;
        rst_i = 1'b1;
        repeat (2) @(negedge clk_i);
        checks++; if (cfi_fault_o !== 1'b0 || fault_cause_o !== 2'd0) begin errors++; $display("FAIL reset_fault: fault=%b cause=%0d want 0/0", cfi_fault_o, fault_cause_o); end
        checks++; if (queue_pop_o !== 1'b0 || chk_req_o !== 1'b0 || flush_done_o !== 1'b0) begin errors++; $display("FAIL reset_ctrl: pop=%b req=%b done=%b want 0", queue_pop_o, chk_req_o, flush_done_o); end
        checks++; if (idle_o !== 1'b1 || checked_cnt_o !== 32'd0) begin errors++; $display("FAIL reset_idle: idle=%b cnt=%0d want 1/0", idle_o, checked_cnt_o); end
        rst_i = 1'b0;
    endtask

    task automatic test_single;
        @(negedge clk_i);
        enable_i = 1'b1;
        chk_gnt_i = 1'b1;
        push(mk(1), 1'b1);
        #1;
        checks++; if (queue_pop_o !== 1'b1) begin errors++; $display("FAIL single_pop: queue_pop_o=%b want 1", queue_pop_o); end
        @(negedge clk_i);
        checks++; if (chk_req_o !== 1'b1 || chk_data_o !== mk(1)) begin errors++; $display("FAIL single_req: req=%b data=%h want 1/%h", chk_req_o, chk_data_o, mk(1)); end
        repeat (2) @(negedge clk_i);
        checks++; if (idle_o !== 1'b0) begin errors++; $display("FAIL single_busy: idle_o=%b want 0", idle_o); end
        @(negedge clk_i);
        chk_rsp_valid_i = 1'b1;
        @(negedge clk_i);
        chk_rsp_valid_i = 1'b0;
        checks++; if (idle_o !== 1'b1 || checked_cnt_o !== 32'd1) begin errors++; $display("FAIL single_done: idle=%b cnt=%0d want 1/1", idle_o, checked_cnt_o); end
    endtask

    task automatic test_outstanding;
        int base;
        base = hs_cnt;
        for (int i = 10; i < 16; i++) push(mk(i), 1'b1);
        repeat (4) @(negedge clk_i);
        checks++; if (hs_cnt - base !== 3) begin errors++; $display("FAIL back_to_back: handshakes=%0d want 3", hs_cnt - base); end
        @(negedge clk_i);
        checks++; if (hs_cnt - base !== 4 || chk_req_o !== 1'b0) begin errors++; $display("FAIL max_out: handshakes=%0d req=%b want 4/0", hs_cnt - base, chk_req_o); end
        repeat (3) @(negedge clk_i);
        checks++; if (hs_cnt - base !== 4 || tl - hd !== 1 || queue_pop_o !== 1'b0) begin errors++; $display("FAIL max_hold: handshakes=%0d queued=%0d pop=%b want 4/1/0", hs_cnt - base, tl - hd, queue_pop_o); end
        chk_rsp_valid_i = 1'b1;
        @(negedge clk_i);
        chk_rsp_valid_i = 1'b0;
        checks++; if (chk_req_o !== 1'b1 || chk_data_o !== mk(14)) begin errors++; $display("FAIL reissue: req=%b data=%h want 1/%h", chk_req_o, chk_data_o, mk(14)); end
    endtask

    task automatic test_check_fault;
        bit seen;
        @(negedge clk_i);
        chk_rsp_valid_i = 1'b1;
        repeat (2) @(negedge clk_i);
        chk_rsp_fault_i = 1'b1;
        @(negedge clk_i);
        chk_rsp_valid_i = 1'b0;
        chk_rsp_fault_i = 1'b0;
        checks++; if (cfi_fault_o !== 1'b1 || fault_cause_o !== 2'd1 || chk_req_o !== 1'b0) begin errors++; $display("FAIL check_fault: fault=%b cause=%0d req=%b want 1/1/0", cfi_fault_o, fault_cause_o, chk_req_o); end
        push(mk(20), 1'b0);
        repeat (20) @(negedge clk_i);
        checks++; if (fault_cause_o !== 2'd1 || tl - hd !== 1 || queue_pop_o !== 1'b0) begin errors++; $display("FAIL fault_hold: cause=%0d queued=%0d pop=%b want 1/1/0", fault_cause_o, tl - hd, queue_pop_o); end
        checks++; if (checked_cnt_o !== 32'd4) begin errors++; $display("FAIL cnt_fault: checked=%0d want 4", checked_cnt_o); end
        chk_rsp_valid_i = 1'b1;
        repeat (2) @(negedge clk_i);
        chk_rsp_valid_i = 1'b0;
        checks++; if (checked_cnt_o !== 32'd6 || fault_cause_o !== 2'd1) begin errors++; $display("FAIL fault_rsp: checked=%0d cause=%0d want 6/1", checked_cnt_o, fault_cause_o); end
        fault_clear_i = 1'b1;
        @(negedge clk_i);
        fault_clear_i = 1'b0;
        wait_done(seen);
        checks++; if (!seen || tl != hd) begin errors++; $display("FAIL check_recover: done_seen=%0b queued=%0d want 1/0", seen, tl - hd); end
        @(negedge clk_i);
        checks++; if (cfi_fault_o !== 1'b0 || fault_cause_o !== 2'd0 || flush_done_o !== 1'b0) begin errors++; $display("FAIL check_cleared: fault=%b cause=%0d done=%b want 0/0/0", cfi_fault_o, fault_cause_o, flush_done_o); end
    endtask

    task automatic test_timeout;
        bit seen;
        push(mk(30), 1'b1);
        @(negedge clk_i);
        checks++; if (chk_req_o !== 1'b1) begin errors++; $display("FAIL tmo_req: req=%b want 1", chk_req_o); end
        repeat (16) @(negedge clk_i);
        checks++; if (fault_cause_o !== 2'd0) begin errors++; $display("FAIL tmo_early: cause=%0d want 0", fault_cause_o); end
        @(negedge clk_i);
        checks++; if (fault_cause_o !== 2'd2 || cfi_fault_o !== 1'b1) begin errors++; $display("FAIL tmo_fault: cause=%0d fault=%b want 2/1", fault_cause_o, cfi_fault_o); end
        chk_rsp_valid_i = 1'b1;
        @(negedge clk_i);
        chk_rsp_valid_i = 1'b0;
        fault_clear_i = 1'b1;
        @(negedge clk_i);
        fault_clear_i = 1'b0;
        wait_done(seen);
        checks++; if (!seen || checked_cnt_o !== 32'd7) begin errors++; $display("FAIL tmo_recover: done_seen=%0b checked=%0d want 1/7", seen, checked_cnt_o); end
        @(negedge clk_i);
        checks++; if (cfi_fault_o !== 1'b0 || idle_o !== 1'b1) begin errors++; $display("FAIL tmo_cleared: fault=%b idle=%b want 0/1", cfi_fault_o, idle_o); end
    endtask

    task automatic test_flush;
        int base;
        base = hs_cnt;
        for (int i = 40; i < 43; i++) push(mk(i), 1'b1);
        for (int i = 0; i < 20 && hs_cnt - base < 3; i++) @(negedge clk_i);
        checks++; if (hs_cnt - base !== 3) begin errors++; $display("FAIL flush_setup: handshakes=%0d want 3", hs_cnt - base); end
        enable_i = 1'b0;
        for (int i = 50; i < 55; i++) push(mk(i), 1'b0);
        flush_i = 1'b1;
        @(negedge clk_i);
        flush_i = 1'b0;
        repeat (3) @(negedge clk_i);
        checks++; if (tl - hd !== 5 || queue_pop_o !== 1'b0 || chk_req_o !== 1'b0) begin errors++; $display("FAIL flush_wait: queued=%0d pop=%b req=%b want 5/0/0", tl - hd, queue_pop_o, chk_req_o); end
        chk_rsp_valid_i = 1'b1;
        repeat (3) @(negedge clk_i);
        chk_rsp_valid_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            checks++; if (queue_pop_o !== 1'b1 || flush_done_o !== 1'b0) begin errors++; $display("FAIL flush_disc[%0d]: pop=%b done=%b want 1/0", i, queue_pop_o, flush_done_o); end
            @(negedge clk_i);
        end
        checks++; if (flush_done_o !== 1'b1 || tl != hd || checked_cnt_o !== 32'd10) begin errors++; $display("FAIL flush_done: done=%b queued=%0d checked=%0d want 1/0/10", flush_done_o, tl - hd, checked_cnt_o); end
        @(negedge clk_i);
        checks++; if (flush_done_o !== 1'b0 || idle_o !== 1'b1) begin errors++; $display("FAIL flush_pulse: done=%b idle=%b want 0/1", flush_done_o, idle_o); end
    endtask

    task automatic test_spurious_reset;
        chk_rsp_valid_i = 1'b1;
        @(negedge clk_i);
        chk_rsp_valid_i = 1'b0;
        checks++; if (fault_cause_o !== 2'd3 || cfi_fault_o !== 1'b1 || checked_cnt_o !== 32'd10) begin errors++; $display("FAIL spurious: cause=%0d fault=%b checked=%0d want 3/1/10", fault_cause_o, cfi_fault_o, checked_cnt_o); end
        push(mk(60), 1'b0);
        push(mk(61), 1'b0);
        fault_clear_i = 1'b1;
        @(negedge clk_i);
        fault_clear_i = 1'b0;
        @(negedge clk_i);
        checks++; if (queue_pop_o !== 1'b1) begin errors++; $display("FAIL mid_flush: pop=%b want 1", queue_pop_o); end
        rst_i = 1'b1;
        @(negedge clk_i);
        checks++; if (cfi_fault_o !== 1'b0 || fault_cause_o !== 2'd0 || flush_done_o !== 1'b0) begin errors++; $display("FAIL rst_fault: fault=%b cause=%0d done=%b want 0/0/0", cfi_fault_o, fault_cause_o, flush_done_o); end
        checks++; if (queue_pop_o !== 1'b0 || chk_req_o !== 1'b0 || checked_cnt_o !== 32'd0) begin errors++; $display("FAIL rst_ctrl: pop=%b req=%b checked=%0d want 0/0/0", queue_pop_o, chk_req_o, checked_cnt_o); end
        rst_i = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_outstanding();
        test_check_fault();
        test_timeout();
        test_flush();
        test_spurious_reset();
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL scoreboard_drain: %0d expected issues never seen, want 0", exp_q.size()); end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
